// File: rtl/transition_histogram.sv
`default_nettype none
// ============================================================================
// Module   : transition_histogram
// Brief    : Hamming-distance histogram of consecutive accepted bus words over
//            a window of WINDOW samples, read back one bin per request.
//            Optional macro TRANS_HIST_TOTAL_EN adds the total_trans output.
// Revision : 1.0  initial release
// ============================================================================
module transition_histogram #(
    parameter int N      = 37,
    parameter int CW     = 11,
    parameter int WINDOW = 2000,
    localparam int IW    = $clog2(N + 1)
`ifdef TRANS_HIST_TOTAL_EN
    ,
    localparam int TW    = $clog2((WINDOW - 1) * N + 1)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [N-1:0]  data_in,
    output logic          busy,
    output logic          done,
    input  logic          rd_req,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [CW-1:0] rd_data
`ifdef TRANS_HIST_TOTAL_EN
    ,
    output logic [TW-1:0] total_trans
`endif
);

    localparam int            SCW      = $clog2(WINDOW + 1);
    localparam logic [SCW-1:0] WIN_LAST = SCW'(WINDOW - 1);
    localparam logic [CW-1:0]  BIN_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q,    state_d;
    logic [CW-1:0]   bins_q [N+1];
    logic [CW-1:0]   bins_d [N+1];
    logic [N-1:0]    prev_q,     prev_d;
    logic [SCW-1:0]  cnt_q,      cnt_d;
    logic            first_q,    first_d;
    logic            pipe_vld_q, pipe_vld_d;
    logic [IW-1:0]   pipe_pc_q,  pipe_pc_d;
    logic            rd_valid_q, rd_valid_d;
    logic [CW-1:0]   rd_data_q,  rd_data_d;
`ifdef TRANS_HIST_TOTAL_EN
    logic [TW-1:0]   total_q,    total_d;
`endif

    function automatic logic [IW-1:0] popcount(input logic [N-1:0] v);
        logic [IW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + IW'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        state_d    = state_q;
        bins_d     = bins_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        pipe_vld_d = 1'b0;
        pipe_pc_d  = pipe_pc_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`ifdef TRANS_HIST_TOTAL_EN
        total_d    = total_q;
`endif

        // Retire the increment registered on the previous accepted sample
        if (pipe_vld_q) begin
            if (bins_q[pipe_pc_q] != BIN_MAX) begin
                bins_d[pipe_pc_q] = bins_q[pipe_pc_q] + CW'(1);
            end
`ifdef TRANS_HIST_TOTAL_EN
            total_d = total_q + TW'(pipe_pc_q);
`endif
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    for (int i = 0; i <= N; i++) begin
                        bins_d[i] = '0;
                    end
`ifdef TRANS_HIST_TOTAL_EN
                    total_d = '0;
`endif
                end else if (rd_req && (state_q == ST_DONE)) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = (rd_idx <= IW'(N)) ? bins_q[rd_idx] : '0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    prev_d  = data_in;
                    cnt_d   = cnt_q + SCW'(1);
                    first_d = 1'b0;
                    // The first sample of a window only seeds the reference word
                    if (!first_q) begin
                        pipe_vld_d = 1'b1;
                        pipe_pc_d  = popcount(data_in ^ prev_q);
                    end
                    if (cnt_q == WIN_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            for (int i = 0; i <= N; i++) begin
                bins_q[i] <= '0;
            end
            prev_q     <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            pipe_vld_q <= 1'b0;
            pipe_pc_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef TRANS_HIST_TOTAL_EN
            total_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bins_q     <= bins_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_pc_q  <= pipe_pc_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef TRANS_HIST_TOTAL_EN
            total_q    <= total_d;
`endif
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`ifdef TRANS_HIST_TOTAL_EN
    assign total_trans = total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transition_histogram.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for transition_histogram: window table with a read-back scoreboard,
// plus hand sequences for reset, start collisions and bin saturation.
module tb_transition_histogram;

    localparam int N    = 37;
    localparam int CW   = 11;
    localparam int WIN  = 4;
    localparam int IW   = $clog2(N + 1);
    localparam int SN   = 8;
    localparam int SCW  = 2;
    localparam int SWIN = 8;
    localparam int SIW  = $clog2(SN + 1);
`ifdef TRANS_HIST_TOTAL_EN
    localparam int TW   = $clog2((WIN - 1) * N + 1);
    localparam int STW  = $clog2((SWIN - 1) * SN + 1);
`endif

    logic          clk;
    logic          rst;
    logic          start, en, rd_req;
    logic [N-1:0]  data_in;
    logic [IW-1:0] rd_idx;
    logic          busy, done, rd_valid;
    logic [CW-1:0] rd_data;

    logic           s_start, s_en, s_rd_req;
    logic [SN-1:0]  s_data;
    logic [SIW-1:0] s_rd_idx;
    logic           s_busy, s_done, s_rd_valid;
    logic [SCW-1:0] s_rd_data;
`ifdef TRANS_HIST_TOTAL_EN
    logic [TW-1:0]  total_trans;
    logic [STW-1:0] s_total;
`endif

    transition_histogram #(.N(N), .CW(CW), .WINDOW(WIN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
`ifdef TRANS_HIST_TOTAL_EN
        ,
        .total_trans (total_trans)
`endif
    );

    transition_histogram #(.N(SN), .CW(SCW), .WINDOW(SWIN)) dut_s (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .en       (s_en),
        .data_in  (s_data),
        .busy     (s_busy),
        .done     (s_done),
        .rd_req   (s_rd_req),
        .rd_idx   (s_rd_idx),
        .rd_valid (s_rd_valid),
        .rd_data  (s_rd_data)
`ifdef TRANS_HIST_TOTAL_EN
        ,
        .total_trans (s_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][N-1:0] s;
        logic [2:0][7:0]   pc;
        logic              gaps;
        logic              start_mid;
    } vec_t;

    typedef struct {
        int     idx;
        longint val;
    } rd_exp_t;

    int       n_checks = 0;
    int       n_pass   = 0;
    int       rdv_cnt  = 0;
    rd_exp_t  exp_q[$];
    vec_t     tbl[5];
    int       eb[N+1];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [N-1:0] a, b, c, d,
                                input int p0, p1, p2, input bit g, sm);
        vec_t v;
        v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
        v.pc[0] = 8'(p0); v.pc[1] = 8'(p1); v.pc[2] = 8'(p2);
        v.gaps = g; v.start_mid = sm;
        return v;
    endfunction

    // Read-back scoreboard: every rd_valid must match the oldest pushed expectation
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rd_valid) begin
                rdv_cnt++;
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("rd_data[%0d]", e.idx), longint'(rd_data), e.val);
                end
            end
        end
    end

    task automatic run_window(input vec_t v, input bit do_start);
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("busy_after_start", busy, 1);
            check("done_after_start", done, 0);
        end
        for (int i = 0; i < 4; i++) begin
            en      = 1'b1;
            data_in = v.s[i];
            if (v.start_mid && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
            en    = 1'b0;
            if (i < 3) begin
                check("done_mid_window", done, 0);
                if (v.gaps) begin
                    data_in = N'({$urandom, $urandom});
                    rd_req  = (i == 0);
                    rd_idx  = '0;
                    tick();
                    rd_req = 1'b0;
                    check("busy_in_gap", busy, 1);
                    if (i == 0) check("rd_ignored_in_run", rd_valid, 0);
                end
            end
        end
        check("busy_in_flush", busy, 1);
        check("done_in_flush", done, 0);
        tick();
        check("done_after_flush", done, 1);
        check("busy_after_flush", busy, 0);
    endtask

    task automatic model_bins(input vec_t v);
        for (int i = 0; i <= N; i++) eb[i] = 0;
        for (int k = 0; k < 3; k++) begin
            if (eb[v.pc[k]] < (1 << CW) - 1) eb[v.pc[k]]++;
        end
    endtask

    task automatic read_all();
        int base;
        rd_exp_t e;
        base   = rdv_cnt;
        rd_req = 1'b1;
        for (int idx = 0; idx <= N + 1; idx++) begin
            e.idx  = (idx <= N) ? idx : 40;
            e.val  = (idx <= N) ? longint'(eb[idx]) : 0;
            rd_idx = IW'(e.idx);
            exp_q.push_back(e);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
        check("rd_valid_count", rdv_cnt - base, N + 2);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    logic [N-1:0] all1;

    initial begin
        all1     = '1;
        rst      = 1'b0;
        start    = 1'b0;
        en       = 1'b0;
        data_in  = '0;
        rd_req   = 1'b0;
        rd_idx   = '0;
        s_start  = 1'b0;
        s_en     = 1'b0;
        s_data   = '0;
        s_rd_req = 1'b0;
        s_rd_idx = '0;

        tbl[0] = mk('0, all1, all1, '0, 37, 0, 37, 1'b0, 1'b0);
        tbl[1] = mk(N'(0), N'(1), N'(3), N'(7), 1, 1, 1, 1'b1, 1'b0);
        tbl[2] = mk(N'(5), N'(5), N'(5), N'(5), 0, 0, 0, 1'b0, 1'b1);
        tbl[3] = mk(N'(0), N'('hF), N'('hF0), N'('hFF), 4, 8, 4, 1'b0, 1'b0);
        tbl[4] = mk(all1, N'(0), N'(1), N'(3), 37, 1, 1, 1'b0, 1'b0);

        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        rst = 1'b1;
        tick();

        for (int r = 0; r < 4; r++) begin
            run_window(tbl[r], 1'b1);
            model_bins(tbl[r]);
`ifdef TRANS_HIST_TOTAL_EN
            check("total_trans", total_trans, tbl[r].pc[0] + tbl[r].pc[1] + tbl[r].pc[2]);
`endif
            read_all();
        end

        // start together with rd_req in DONE: start wins, window re-armed
        start  = 1'b1;
        rd_req = 1'b1;
        rd_idx = IW'(8);
        tick();
        start  = 1'b0;
        rd_req = 1'b0;
        check("start_rd_no_valid", rd_valid, 0);
        check("start_rd_busy", busy, 1);
        check("start_rd_done", done, 0);
        run_window(tbl[4], 1'b0);
        model_bins(tbl[4]);
        read_all();

        // Reset in the middle of a window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en      = 1'b1;
            data_in = N'(i * 3 + 1);
            tick();
        end
        en  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_data", rd_data, 0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("rd_ignored_idle", rd_valid, 0);
        run_window(tbl[0], 1'b1);
        model_bins(tbl[0]);
        read_all();

        // Saturation on the narrow-counter instance
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_data  = SN'('hA5);
        s_en    = 1'b1;
        for (int i = 0; i < SWIN; i++) begin
            tick();
            if (i < SWIN - 1) check("sat_busy_mid", s_busy, 1);
        end
        s_en = 1'b0;
        check("sat_done_flush", s_done, 0);
        tick();
        check("sat_done", s_done, 1);
`ifdef TRANS_HIST_TOTAL_EN
        check("sat_total", s_total, 0);
`endif
        for (int idx = 0; idx <= SN; idx++) begin
            s_rd_req = 1'b1;
            s_rd_idx = SIW'(idx);
            tick();
            check("sat_rd_valid", s_rd_valid, 1);
            check($sformatf("sat_bin[%0d]", idx), s_rd_data, (idx == 0) ? 3 : 0);
        end
        s_rd_req = 1'b0;
        tick();
        check("sat_rd_valid_drop", s_rd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
